// File: rtl/button_conditioner_if.sv
// Button-to-FSM bundle: raw button levels in, conditioned press pulses and status out.
interface button_conditioner_if;
  logic       btnCenter;
  logic       btnTop;
  logic       btnBottom;
  logic       btnLeft;
  logic       btnRight;
  logic       pressCenter;
  logic       pressTop;
  logic       pressBottom;
  logic       pressLeft;
  logic       pressRight;
  logic [2:0] press_code;
  logic [4:0] held;
  logic       ready;

  modport slave (
    input  btnCenter, btnTop, btnBottom, btnLeft, btnRight,
    output pressCenter, pressTop, pressBottom, pressLeft, pressRight,
    output press_code, held, ready
  );

  modport master (
    output btnCenter, btnTop, btnBottom, btnLeft, btnRight,
    input  pressCenter, pressTop, pressBottom, pressLeft, pressRight,
    input  press_code, held, ready
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects five push-buttons into single prioritized
// one-cycle press pulses, suppressing presses during a start-up lockout.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn_if
);

  localparam int unsigned N_BTN        = 5;
  localparam int unsigned CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned START_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned START_W      = $clog2(START_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  logic [N_BTN-1:0]       btn_raw;
  logic [SYNC_STAGES-1:0] sync_q [N_BTN];
  logic [CNT_W-1:0]       cnt_q  [N_BTN];
  logic [N_BTN-1:0]       sync_out;
  logic [N_BTN-1:0]       stable_q;
  logic [N_BTN-1:0]       stable_d_q;
  logic [N_BTN-1:0]       rise_c;

  state_t             state_q, state_nxt;
  logic [START_W-1:0] start_cnt_q, start_cnt_nxt;
  logic [N_BTN-1:0]   press_q, press_nxt;
  logic [2:0]         code_q, code_nxt;
  logic               ready_q, ready_nxt;

  always_comb begin
    btn_raw = {btn_if.btnRight, btn_if.btnLeft, btn_if.btnBottom,
               btn_if.btnTop, btn_if.btnCenter};
  end

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < N_BTN; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Per-button synchronizer and debounce filter; any return to the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q   <= '0;
      stable_d_q <= '0;
    end else begin
      stable_d_q <= stable_q;
      for (int i = 0; i < N_BTN; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
        if (sync_out[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync_out[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise_c = stable_q & ~stable_d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_STARTUP;
      start_cnt_q <= '0;
      press_q     <= '0;
      code_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      start_cnt_q <= start_cnt_nxt;
      press_q     <= press_nxt;
      code_q      <= code_nxt;
      ready_q     <= ready_nxt;
    end
  end

  // Lockout sequencing and fixed-priority pulse selection; losing requests are dropped.
  always_comb begin
    state_nxt     = state_q;
    start_cnt_nxt = start_cnt_q;
    press_nxt     = '0;
    code_nxt      = 3'd0;
    unique case (state_q)
      ST_STARTUP: begin
        if (start_cnt_q == START_LAST) begin
          state_nxt     = ST_RUN;
          start_cnt_nxt = '0;
        end else begin
          start_cnt_nxt = start_cnt_q + START_W'(1);
        end
      end
      ST_RUN: begin
        if (rise_c[0]) begin
          press_nxt = 5'b00001;
          code_nxt  = 3'd1;
        end else if (rise_c[1]) begin
          press_nxt = 5'b00010;
          code_nxt  = 3'd2;
        end else if (rise_c[2]) begin
          press_nxt = 5'b00100;
          code_nxt  = 3'd3;
        end else if (rise_c[3]) begin
          press_nxt = 5'b01000;
          code_nxt  = 3'd4;
        end else if (rise_c[4]) begin
          press_nxt = 5'b10000;
          code_nxt  = 3'd5;
        end
      end
      default: state_nxt = ST_STARTUP;
    endcase
    ready_nxt = (state_nxt == ST_RUN);
  end

  assign btn_if.pressCenter = press_q[0];
  assign btn_if.pressTop    = press_q[1];
  assign btn_if.pressBottom = press_q[2];
  assign btn_if.pressLeft   = press_q[3];
  assign btn_if.pressRight  = press_q[4];
  assign btn_if.press_code  = code_q;
  assign btn_if.held        = stable_q;
  assign btn_if.ready       = ready_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses go into a scoreboard queue,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned SYN = 2;
  localparam int unsigned LAT = SYN + DEB;

  typedef struct {
    int code;
    int at_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_if(bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n = edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int press_vec();
    return int'({bif.pressRight, bif.pressLeft, bif.pressBottom, bif.pressTop, bif.pressCenter});
  endfunction

  // Scoreboard monitor: every observed pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (press_vec() != 0 || bif.press_code != 3'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", press_vec(), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_code", int'(bif.press_code), e.code);
        check("pulse_vec", press_vec(), 1 << (e.code - 1));
        check("pulse_edge", edge_n, e.at_edge);
      end
    end
  end

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: bif.btnCenter = v;
      1: bif.btnTop    = v;
      2: bif.btnBottom = v;
      3: bif.btnLeft   = v;
      default: bif.btnRight = v;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic expect_press(input int code, input int e0);
    exp_t e;
    e.code    = code;
    e.at_edge = e0 + int'(LAT);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bif.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bif.ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_press"}, press_vec(), 0);
    check({tag, "_code"}, int'(bif.press_code), 0);
    check({tag, "_held"}, int'(bif.held), 0);
    check({tag, "_ready"}, int'(bif.ready), 0);
  endtask

  initial begin
    int e0;
    int rel;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) set_btn(i, 1'b0);

    // Reset state
    apply_reset();
    check_idle("reset");
    wait_ready();

    // Clean press of Top and later release
    @(negedge clk);
    e0 = edge_n + 1;
    set_btn(1, 1'b1);
    expect_press(2, e0);
    wait_edge(e0 + 4);
    check("top_held_early", int'(bif.held[1]), 0);
    wait_edge(e0 + 5);
    check("top_held", int'(bif.held[1]), 1);
    wait_edge(e0 + 10);
    rel = edge_n + 1;
    set_btn(1, 1'b0);
    wait_edge(rel + 4);
    check("top_release_early", int'(bif.held[1]), 1);
    wait_edge(rel + 5);
    check("top_released", int'(bif.held[1]), 0);
    tick(3);

    // Bounce on Left: 1,0,1,0,1,0 never reaches the debounce threshold
    for (int i = 0; i < 6; i++) begin
      set_btn(3, (i % 2) == 0);
      @(negedge clk);
      check("bounce_held", int'(bif.held[3]), 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bounce_settle_held", int'(bif.held[3]), 0);
    end

    // Left high for exactly four sampled cycles is just long enough
    e0 = edge_n + 1;
    set_btn(3, 1'b1);
    expect_press(4, e0);
    tick(4);
    set_btn(3, 1'b0);
    wait_edge(e0 + 5);
    check("left_short_held", int'(bif.held[3]), 1);
    tick(12);
    check("left_short_released", int'(bif.held[3]), 0);

    // Simultaneous Center and Right: only Center pulses
    e0 = edge_n + 1;
    set_btn(0, 1'b1);
    set_btn(4, 1'b1);
    expect_press(1, e0);
    wait_edge(e0 + 5);
    check("simul_held", int'(bif.held), 5'b10001);
    wait_edge(e0 + 10);
    set_btn(0, 1'b0);
    set_btn(4, 1'b0);
    tick(10);
    check("simul_released", int'(bif.held), 0);

    // Staggered: Right one edge after Center, both pulse in order
    e0 = edge_n + 1;
    set_btn(0, 1'b1);
    expect_press(1, e0);
    @(negedge clk);
    set_btn(4, 1'b1);
    expect_press(5, e0 + 1);
    wait_edge(e0 + 10);
    check("stagger_held", int'(bif.held), 5'b10001);
    set_btn(0, 1'b0);
    set_btn(4, 1'b0);
    tick(10);

    // Bottom held through reset: lockout swallows the rise
    set_btn(2, 1'b1);
    apply_reset();
    rel = edge_n;
    wait_edge(rel + 6);
    check("lockout_ready_low", int'(bif.ready), 0);
    wait_edge(rel + 7);
    check("lockout_ready_high", int'(bif.ready), 1);
    check("lockout_held", int'(bif.held[2]), 1);
    tick(8);
    set_btn(2, 1'b0);
    tick(10);
    check("lockout_released", int'(bif.held[2]), 0);
    e0 = edge_n + 1;
    set_btn(2, 1'b1);
    expect_press(3, e0);
    wait_edge(e0 + 10);
    set_btn(2, 1'b0);
    tick(10);

    // Reset lands on the edge where the Top pulse would fire
    e0 = edge_n + 1;
    set_btn(1, 1'b1);
    wait_edge(e0 + 5);
    check("midreset_pre_held", int'(bif.held[1]), 1);
    reset = 1'b1;
    wait_edge(e0 + 6);
    check_idle("midreset");
    set_btn(1, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(12);

    check("missing_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
